// File: rtl/multicycle_control_unit.sv
// Moore control FSM for a shared-ALU, shared-memory multicycle MIPS datapath.
// Stalls on mem_ready, flags unsupported opcodes and counts retired instructions.
module multicycle_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCEn,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        J       = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       fetch;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        logic [2:0] a;
        case (funct)
            6'b100010: a = ALU_SUB;
            6'b100100: a = ALU_AND;
            6'b100101: a = ALU_OR;
            6'b101010: a = ALU_SLT;
            default:   a = ALU_ADD;
        endcase
        return a;
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_ctl   = ALU_ADD;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_ctl   = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_ctl   = ALU_ADD;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            RTYPEEX: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = alu_from_funct(funct);
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ADDIWB: c.reg_write = 1'b1;
            BEQ: begin
                c.alu_src_a = 1'b1;
                c.alu_ctl   = ALU_SUB;
                c.pc_src    = 2'b01;
                c.branch    = 1'b1;
            end
            J: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = J;
                    default: begin
                        state_d    = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            RTYPEEX: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BEQ, J: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        ctrl_d    = decode_ctrl(state_d, Funct);
        retired_d = retired_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            ctrl_q    <= decode_ctrl(FETCH, 6'd0);
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            retired_q <= retired_d;
        end
    end

    // Write enables are also gated by reset so they drop the instant it asserts.
    assign IorD       = ctrl_q.iord;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = reset & ctrl_q.mem_write;
    assign IRWrite    = reset & ctrl_q.fetch & mem_ready;
    assign PCEn       = reset & ((ctrl_q.fetch & mem_ready) | ctrl_q.pc_write |
                                 (ctrl_q.branch & Zero));
    assign PCSrc      = ctrl_q.pc_src;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ALUControl = ctrl_q.alu_ctl;
    assign RegDst     = ctrl_q.reg_dst;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = reset & ctrl_q.reg_write;
    assign retired    = retired_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle control vectors and state
// against hand-computed tables, plus retired-count scoreboard with a 3-bit wrap.
module tb_multicycle_control_unit;

    localparam int CNT_W = 3;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMRD = 4'd3, S_MEMWB = 4'd4, S_MEMWR = 4'd5,
                           S_RTYPEEX = 4'd6, S_ALUWB = 4'd7, S_BEQ = 4'd8,
                           S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_J = 4'd11;

    // {IorD,MemRead,MemWrite,IRWrite,PCEn,PCSrc,ALUSrcA,ALUSrcB,ALUControl,RegDst,MemtoReg,RegWrite,illegal_op}
    localparam logic [16:0] V_FETCH1 = 17'b0_1_0_1_1_00_0_01_010_0_0_0_0;
    localparam logic [16:0] V_FETCH0 = 17'b0_1_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [16:0] V_DEC    = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
    localparam logic [16:0] V_DECILL = 17'b0_0_0_0_0_00_0_11_010_0_0_0_1;
    localparam logic [16:0] V_MADR   = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] V_MRD    = 17'b1_1_0_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] V_MWB    = 17'b0_0_0_0_0_00_0_00_000_0_1_1_0;
    localparam logic [16:0] V_MWR    = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
    localparam logic [16:0] V_RSLT   = 17'b0_0_0_0_0_00_1_00_111_0_0_0_0;
    localparam logic [16:0] V_RSUB   = 17'b0_0_0_0_0_00_1_00_110_0_0_0_0;
    localparam logic [16:0] V_RDEF   = 17'b0_0_0_0_0_00_1_00_010_0_0_0_0;
    localparam logic [16:0] V_AWB    = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
    localparam logic [16:0] V_BEQ1   = 17'b0_0_0_0_1_01_1_00_110_0_0_0_0;
    localparam logic [16:0] V_BEQ0   = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
    localparam logic [16:0] V_AEX    = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [16:0] V_IWB    = 17'b0_0_0_0_0_00_0_00_000_0_0_1_0;
    localparam logic [16:0] V_J      = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       Op, Funct;
    logic             Zero, mem_ready;
    logic             IorD, MemRead, MemWrite, IRWrite, PCEn;
    logic [1:0]       PCSrc, ALUSrcB;
    logic             ALUSrcA, RegDst, MemtoReg, RegWrite, illegal_op;
    logic [2:0]       ALUControl;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;
    logic [16:0]      ctl_vec;

    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic [CNT_W-1:0] exp_q[$];

    multicycle_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op),
        .retired(retired), .state_dbg(state_dbg)
    );

    assign ctl_vec = {IorD, MemRead, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                      ALUControl, RegDst, MemtoReg, RegWrite, illegal_op};

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Check one cycle at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic [16:0] v, input logic [3:0] s);
        @(negedge clk);
        check({tag, ".ctl"}, 32'(ctl_vec), 32'(v));
        check({tag, ".st"}, 32'(state_dbg), 32'(s));
        @(posedge clk);
        #1;
    endtask

    task automatic retire_one();
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic ret_check(input string tag);
        logic [CNT_W-1:0] e;
        exp_q.push_back(exp_ret);
        e = exp_q.pop_front();
        check(tag, 32'(retired), 32'(e));
    endtask

    initial begin
        reset = 1'b0; mem_ready = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst.st", 32'(state_dbg), 32'(S_FETCH));
        check("rst.ret", 32'(retired), 32'd0);
        check("rst.en", 32'({MemWrite, IRWrite, PCEn, RegWrite}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // lw, no stalls: 5 cycles
        Op = 6'b100011;
        cyc("lw.f", V_FETCH1, S_FETCH);
        cyc("lw.d", V_DEC, S_DECODE);
        cyc("lw.a", V_MADR, S_MEMADR);
        cyc("lw.r", V_MRD, S_MEMRD);
        cyc("lw.w", V_MWB, S_MEMWB);
        retire_one(); ret_check("lw.ret");

        // sw with 3 stall cycles in MEMWR: 7 cycles
        Op = 6'b101011;
        cyc("sw.f", V_FETCH1, S_FETCH);
        cyc("sw.d", V_DEC, S_DECODE);
        cyc("sw.a", V_MADR, S_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw.stall", V_MWR, S_MEMWR);
        mem_ready = 1'b1;
        cyc("sw.w", V_MWR, S_MEMWR);
        retire_one(); ret_check("sw.ret");

        // R-type: slt, sub, unknown funct defaults to add
        Op = 6'b000000; Funct = 6'b101010;
        cyc("slt.f", V_FETCH1, S_FETCH);
        cyc("slt.d", V_DEC, S_DECODE);
        cyc("slt.x", V_RSLT, S_RTYPEEX);
        cyc("slt.w", V_AWB, S_ALUWB);
        retire_one(); ret_check("slt.ret");
        Funct = 6'b100010;
        cyc("sub.f", V_FETCH1, S_FETCH);
        cyc("sub.d", V_DEC, S_DECODE);
        cyc("sub.x", V_RSUB, S_RTYPEEX);
        cyc("sub.w", V_AWB, S_ALUWB);
        retire_one(); ret_check("sub.ret");
        Funct = 6'b100111;
        cyc("rdef.f", V_FETCH1, S_FETCH);
        cyc("rdef.d", V_DEC, S_DECODE);
        cyc("rdef.x", V_RDEF, S_RTYPEEX);
        cyc("rdef.w", V_AWB, S_ALUWB);
        retire_one(); ret_check("rdef.ret");

        // beq taken / not taken
        Op = 6'b000100;
        cyc("beq1.f", V_FETCH1, S_FETCH);
        cyc("beq1.d", V_DEC, S_DECODE);
        Zero = 1'b1;
        cyc("beq1.b", V_BEQ1, S_BEQ);
        Zero = 1'b0;
        retire_one(); ret_check("beq1.ret");
        cyc("beq0.f", V_FETCH1, S_FETCH);
        cyc("beq0.d", V_DEC, S_DECODE);
        cyc("beq0.b", V_BEQ0, S_BEQ);
        retire_one(); ret_check("beq0.ret");

        // j: counter wraps 7 -> 0 here
        Op = 6'b000010;
        cyc("j.f", V_FETCH1, S_FETCH);
        cyc("j.d", V_DEC, S_DECODE);
        cyc("j.j", V_J, S_J);
        retire_one(); ret_check("j.ret");

        // addi writes rt
        Op = 6'b001000;
        cyc("addi.f", V_FETCH1, S_FETCH);
        cyc("addi.d", V_DEC, S_DECODE);
        cyc("addi.x", V_AEX, S_ADDIEX);
        cyc("addi.w", V_IWB, S_ADDIWB);
        retire_one(); ret_check("addi.ret");

        // fetch stall, then illegal opcode
        Op = 6'b111111; mem_ready = 1'b0;
        cyc("ill.f0", V_FETCH0, S_FETCH);
        mem_ready = 1'b1;
        cyc("ill.f", V_FETCH1, S_FETCH);
        cyc("ill.d", V_DECILL, S_DECODE);
        ret_check("ill.ret");
        cyc("ill.back", V_FETCH1, S_FETCH);

        // reset asserted while stalled in MEMRD
        Op = 6'b100011;
        cyc("rs.d", V_DEC, S_DECODE);
        cyc("rs.a", V_MADR, S_MEMADR);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rs.r.ctl", 32'(ctl_vec), 32'(V_MRD));
        check("rs.r.st", 32'(state_dbg), 32'(S_MEMRD));
        #2 reset = 1'b0; mem_ready = 1'b1;
        #1;
        check("rs.async.st", 32'(state_dbg), 32'(S_FETCH));
        check("rs.async.en", 32'({MemWrite, IRWrite, PCEn, RegWrite}), 32'd0);
        exp_ret = '0;
        ret_check("rs.async.ret");
        @(posedge clk);
        #1 reset = 1'b1;
        cyc("rs.f", V_FETCH1, S_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
